// File: rtl/apb_master.sv
// APB master: takes one command at a time, runs SETUP/ACCESS on the APB bus and
// returns a one-cycle response carrying read data, slave error or timeout.
module apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_wait_cnt;
   logic [CNT_W-1:0]    w_wait_cnt_nxt;
   logic                r_psel;
   logic                w_psel_nxt;
   logic                r_penable;
   logic                w_penable_nxt;
   logic                r_pwrite;
   logic                w_pwrite_nxt;
   logic [ADDR_W-1:0]   r_paddr;
   logic [ADDR_W-1:0]   w_paddr_nxt;
   logic [DATA_W-1:0]   r_pwdata;
   logic [DATA_W-1:0]   w_pwdata_nxt;
   logic                r_rsp_valid;
   logic                w_rsp_valid_nxt;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [DATA_W-1:0]   w_rsp_rdata_nxt;
   logic                r_rsp_err;
   logic                w_rsp_err_nxt;
   logic                r_rsp_timeout;
   logic                w_rsp_timeout_nxt;
   logic                w_slverr;

   // pslverr only counts during a completing access phase
   assign w_slverr = pslverr & r_psel & r_penable & pready;

   // Next-state and next-register values; response fields are a single-cycle pulse
   always_comb begin
      w_state_nxt       = r_state;
      w_wait_cnt_nxt    = r_wait_cnt;
      w_psel_nxt        = r_psel;
      w_penable_nxt     = r_penable;
      w_pwrite_nxt      = r_pwrite;
      w_paddr_nxt       = r_paddr;
      w_pwdata_nxt      = r_pwdata;
      w_rsp_valid_nxt   = 1'b0;
      w_rsp_rdata_nxt   = {DATA_W{1'b0}};
      w_rsp_err_nxt     = 1'b0;
      w_rsp_timeout_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            if (cmd_valid) begin
               w_state_nxt   = ST_SETUP;
               w_psel_nxt    = 1'b1;
               w_pwrite_nxt  = cmd_write;
               w_paddr_nxt   = cmd_addr;
               w_pwdata_nxt  = cmd_wdata;
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_SETUP: begin
            w_state_nxt    = ST_ACCESS;
            w_psel_nxt     = 1'b1;
            w_penable_nxt  = 1'b1;
            w_wait_cnt_nxt = {CNT_W{1'b0}};
         end
         ST_ACCESS: begin
            if (pready) begin
               w_state_nxt     = ST_IDLE;
               w_psel_nxt      = 1'b0;
               w_penable_nxt   = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_rsp_err_nxt   = w_slverr;
               w_rsp_rdata_nxt = r_pwrite ? {DATA_W{1'b0}} : prdata;
            end else if (r_wait_cnt == CNT_LAST) begin
               // This wait cycle brings the counter to TIMEOUT: abandon the slave
               w_state_nxt       = ST_IDLE;
               w_wait_cnt_nxt    = r_wait_cnt + CNT_ONE;
               w_psel_nxt        = 1'b0;
               w_penable_nxt     = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_rsp_err_nxt     = 1'b1;
               w_rsp_timeout_nxt = 1'b1;
            end else begin
               w_wait_cnt_nxt    = r_wait_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
         end
      endcase
   end

   // State and output registers, cleared asynchronously by nreset
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state       <= ST_IDLE;
         r_wait_cnt    <= {CNT_W{1'b0}};
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= {ADDR_W{1'b0}};
         r_pwdata      <= {DATA_W{1'b0}};
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= {DATA_W{1'b0}};
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_psel        <= w_psel_nxt;
         r_penable     <= w_penable_nxt;
         r_pwrite      <= w_pwrite_nxt;
         r_paddr       <= w_paddr_nxt;
         r_pwdata      <= w_pwdata_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_rdata   <= w_rsp_rdata_nxt;
         r_rsp_err     <= w_rsp_err_nxt;
         r_rsp_timeout <= w_rsp_timeout_nxt;
      end
   end

   assign cmd_ready   = (r_state == ST_IDLE);
   assign psel        = r_psel;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite;
   assign paddr       = r_paddr;
   assign pwdata      = r_pwdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle-exact bus checks plus a response scoreboard.
module tb_apb_master;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              nreset;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              psel, penable, pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata, prdata;
   logic              pready, pslverr;
   logic              rsp_valid, rsp_err, rsp_timeout;
   logic [DATA_W-1:0] rsp_rdata;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      logic              tmo;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .nreset(nreset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void push(input logic [DATA_W-1:0] d, input logic e, input logic t);
      rsp_t r;
      r.rdata = d;
      r.err   = e;
      r.tmo   = t;
      exp_q.push_back(r);
   endfunction

   task automatic sb_check(input string tag);
      rsp_t e;
      chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'h1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
         chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
         chk({tag, "_tmo"}, 32'(rsp_timeout), 32'(e.tmo));
      end
   endtask

   task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nreset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
      #1;
      chk("rst_psel", 32'(psel), 32'h0);
      chk("rst_penable", 32'(penable), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_paddr", 32'(paddr), 32'h0);
      chk("rst_pwdata", 32'(pwdata), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      #20;
      @(negedge clk);
      nreset = 1'b1;
      tick();

      // Zero-wait write; prdata junk must not leak into rsp_rdata
      prdata = 16'hBEEF; pready = 1'b1;
      send(1'b1, 8'h04, 16'h00A4);
      push(16'h0000, 1'b0, 1'b0);
      chk("wr_setup_sel_en", 32'({psel, penable}), 32'h2);
      chk("wr_setup_paddr", 32'(paddr), 32'h04);
      chk("wr_setup_pwdata", 32'(pwdata), 32'h00A4);
      chk("wr_setup_pwrite", 32'(pwrite), 32'h1);
      chk("wr_setup_cmd_ready", 32'(cmd_ready), 32'h0);
      tick();
      chk("wr_acc_sel_en", 32'({psel, penable}), 32'h3);
      chk("wr_acc_pwdata", 32'(pwdata), 32'h00A4);
      chk("wr_acc_rsp_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("wr_rsp_sel_en", 32'({psel, penable}), 32'h0);
      chk("wr_rsp_cmd_ready", 32'(cmd_ready), 32'h1);
      chk("wr_idle_pwdata_hold", 32'(pwdata), 32'h00A4);
      sb_check("wr");
      tick();
      chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

      // Read with two wait states; pslverr asserted while not ready is ignored
      pready = 1'b0; pslverr = 1'b1; prdata = 16'h0000;
      send(1'b0, 8'h08, 16'h0000);
      push(16'h00DF, 1'b0, 1'b0);
      chk("rd_setup_sel_en", 32'({psel, penable}), 32'h2);
      tick();
      chk("rd_acc1", 32'({psel, penable}), 32'h3);
      tick();
      chk("rd_acc2", 32'({psel, penable}), 32'h3);
      tick();
      pslverr = 1'b0; pready = 1'b1; prdata = 16'h00DF;
      chk("rd_acc3", 32'({psel, penable}), 32'h3);
      chk("rd_acc3_no_rsp", 32'(rsp_valid), 32'h0);
      tick();
      prdata = 16'h0000;
      chk("rd_rsp_psel", 32'(psel), 32'h0);
      sb_check("rd_wait");

      // Slave error
      pready = 1'b1; pslverr = 1'b1;
      send(1'b1, 8'h0C, 16'h0069);
      push(16'h0000, 1'b1, 1'b0);
      tick();
      chk("err_acc", 32'({psel, penable}), 32'h3);
      tick();
      pslverr = 1'b0;
      sb_check("slverr");

      // Timeout: exactly TIMEOUT ACCESS cycles without pready
      pready = 1'b0; prdata = 16'h1234;
      send(1'b0, 8'h10, 16'h0000);
      push(16'h0000, 1'b1, 1'b1);
      for (int i = 0; i < TIMEOUT; i++) begin
         tick();
         chk("tmo_acc", 32'({psel, penable}), 32'h3);
      end
      tick();
      chk("tmo_sel_en", 32'({psel, penable}), 32'h0);
      sb_check("tmo");

      // pready arriving in the last allowed ACCESS cycle beats the timeout
      pready = 1'b0; prdata = 16'h5A5A;
      send(1'b0, 8'h14, 16'h0000);
      push(16'h5A5A, 1'b0, 1'b0);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         tick();
      end
      tick();
      pready = 1'b1;
      chk("edge_acc16", 32'({psel, penable}), 32'h3);
      tick();
      sb_check("edge_ready");

      // Reset in the second ACCESS cycle aborts with no response
      pready = 1'b0;
      send(1'b1, 8'h20, 16'h1111);
      tick();
      tick();
      #2 nreset = 1'b0;
      #1;
      chk("mrst_sel_en", 32'({psel, penable}), 32'h0);
      chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mrst_paddr", 32'(paddr), 32'h0);
      chk("mrst_cmd_ready", 32'(cmd_ready), 32'h1);
      @(negedge clk);
      nreset = 1'b1; pready = 1'b1;
      tick();
      chk("mrst_rel_cmd_ready", 32'(cmd_ready), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("mrst_no_rsp", 32'({rsp_valid, psel}), 32'h0);
         tick();
      end

      // Busy: second command held from SETUP is taken only in the response cycle
      pready = 1'b0;
      send(1'b1, 8'h30, 16'hAAAA);
      push(16'h0000, 1'b0, 1'b0);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40; cmd_wdata = 16'h5555;
      push(16'h7777, 1'b0, 1'b0);
      chk("busy_setup_paddr", 32'(paddr), 32'h30);
      tick();
      chk("busy_acc1_paddr", 32'(paddr), 32'h30);
      chk("busy_acc1_cmd_ready", 32'(cmd_ready), 32'h0);
      tick();
      pready = 1'b1;
      chk("busy_acc2_paddr", 32'(paddr), 32'h30);
      chk("busy_acc2_pwdata", 32'(pwdata), 32'hAAAA);
      chk("busy_acc2_pwrite", 32'(pwrite), 32'h1);
      tick();
      chk("busy_rsp_cmd_ready", 32'(cmd_ready), 32'h1);
      sb_check("busy1");
      prdata = 16'h7777;
      tick();
      cmd_valid = 1'b0;
      chk("busy2_setup_sel_en", 32'({psel, penable}), 32'h2);
      chk("busy2_paddr", 32'(paddr), 32'h40);
      chk("busy2_pwrite", 32'(pwrite), 32'h0);
      chk("busy2_no_rsp", 32'(rsp_valid), 32'h0);
      tick();
      chk("busy2_acc", 32'({psel, penable}), 32'h3);
      tick();
      sb_check("busy2");

      chk("sb_drain", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
